// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcode mnemonics, FSM state
// encoding, control-class sub-opcodes and instruction field positions.
package alu_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    mcADD = 3'b000,
    mcSUB = 3'b001,
    mcAND = 3'b010,
    mcOR  = 3'b011,
    mcXOR = 3'b100,
    mcNOT = 3'b101,
    mcSHL = 3'b110,
    mcSHR = 3'b111
  } op_mne;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [1:0] SUB_BEQ  = 2'b00;
  localparam logic [1:0] SUB_BLT  = 2'b01;
  localparam logic [1:0] SUB_CMP  = 2'b10;
  localparam logic [1:0] SUB_HALT = 2'b11;

  localparam int CLASS_BIT  = 8;
  localparam int ALU_OP_MSB = 7;
  localparam int ALU_OP_LSB = 5;
  localparam int RD_MSB     = 4;
  localparam int RD_LSB     = 2;
  localparam int RS_MSB     = 1;
  localparam int CSUB_MSB   = 7;
  localparam int CSUB_LSB   = 6;
  localparam int CA_MSB     = 5;
  localparam int CA_LSB     = 3;
  localparam int CB_MSB     = 2;
  localparam int OFF_MSB    = 5;
  localparam int OFF_W      = OFF_MSB + 1;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decoder: splits the held instruction register into class
// flags, ALU opcode, register addresses and the sign-extended branch offset.
module alu_issue_decode
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DW = 8,
  parameter int IW = 9
) (
  input  logic [IW-1:0] ir,
  output logic          is_alu,
  output logic          is_cmp,
  output logic          is_beq,
  output logic          is_blt,
  output logic          is_branch,
  output logic          is_halt,
  output logic [2:0]    alu_op,
  output logic [2:0]    raddr_a,
  output logic [2:0]    raddr_b,
  output logic [2:0]    waddr,
  output logic [DW-1:0] offset
);

  logic [1:0] sub_op;

  always_comb begin
    sub_op    = ir[CSUB_MSB:CSUB_LSB];
    is_alu    = 1'b0;
    is_cmp    = 1'b0;
    is_beq    = 1'b0;
    is_blt    = 1'b0;
    is_halt   = 1'b0;
    alu_op    = mcADD;
    raddr_a   = 3'd0;
    raddr_b   = 3'd0;
    waddr     = 3'd0;
    if (!ir[CLASS_BIT]) begin
      // rd is both the A source and the destination
      is_alu  = 1'b1;
      alu_op  = ir[ALU_OP_MSB:ALU_OP_LSB];
      raddr_a = ir[RD_MSB:RD_LSB];
      raddr_b = {1'b0, ir[RS_MSB:0]};
      waddr   = ir[RD_MSB:RD_LSB];
    end else begin
      case (sub_op)
        SUB_BEQ: is_beq = 1'b1;
        SUB_BLT: is_blt = 1'b1;
        SUB_CMP: begin
          is_cmp  = 1'b1;
          alu_op  = mcSUB;
          raddr_a = ir[CA_MSB:CA_LSB];
          raddr_b = ir[CB_MSB:0];
        end
        default: is_halt = 1'b1;
      endcase
    end
    is_branch = is_beq | is_blt;
  end

  assign offset = {{(DW-OFF_W){ir[OFF_MSB]}}, ir[OFF_MSB:0]};

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller FSM (IDLE/DECODE/EXEC/WB/HALT) driving register file, ALU
// and PC. Optional retired-instruction counter: define ALU_ISSUE_PERF_CNT_EN.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IW    = 9,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             instr_valid,
  input  logic [IW-1:0]    instr,
  output logic             instr_ready,
  output logic [2:0]       rf_raddr_a,
  output logic [2:0]       rf_raddr_b,
  output logic [2:0]       rf_waddr,
  output logic             rf_we,
  output logic [DW-1:0]    rf_wdata,
  output logic [2:0]       alu_op,
  input  logic [DW-1:0]    alu_result,
  input  logic             alu_equals,
  input  logic             alu_lt,
  output logic             eq_flag,
  output logic             lt_flag,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [DW-1:0]    pc_offset,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  logic [2:0]    state_reg, state_next;
  logic [IW-1:0] ir_reg;
  logic [DW-1:0] result_reg;
  logic          eq_flag_reg, lt_flag_reg;
  logic [2:0]    raddr_a_reg, raddr_b_reg;

  logic          dec_alu, dec_cmp, dec_beq, dec_blt, dec_branch, dec_halt;
  logic [2:0]    dec_alu_op, dec_raddr_a, dec_raddr_b, dec_waddr;
  logic [DW-1:0] dec_offset;
  logic          in_wb, branch_taken;

  alu_issue_decode #(.DW(DW), .IW(IW)) u_decode (
    .ir        (ir_reg),
    .is_alu    (dec_alu),
    .is_cmp    (dec_cmp),
    .is_beq    (dec_beq),
    .is_blt    (dec_blt),
    .is_branch (dec_branch),
    .is_halt   (dec_halt),
    .alu_op    (dec_alu_op),
    .raddr_a   (dec_raddr_a),
    .raddr_b   (dec_raddr_b),
    .waddr     (dec_waddr),
    .offset    (dec_offset)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (instr_valid) state_next = ST_DECODE;
      ST_DECODE: state_next = dec_halt ? ST_HALT : ST_EXEC;
      ST_EXEC:   state_next = ST_WB;
      ST_WB:     state_next = ST_IDLE;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg   <= ST_IDLE;
      ir_reg      <= '0;
      result_reg  <= '0;
      eq_flag_reg <= 1'b0;
      lt_flag_reg <= 1'b0;
      raddr_a_reg <= 3'd0;
      raddr_b_reg <= 3'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && instr_valid)
        ir_reg <= instr;
      if (state_reg == ST_DECODE) begin
        raddr_a_reg <= dec_raddr_a;
        raddr_b_reg <= dec_raddr_b;
      end
      // Branches leave the flags alone so they can test the last ALU/CMP result
      if (state_reg == ST_EXEC && (dec_alu || dec_cmp)) begin
        result_reg  <= alu_result;
        eq_flag_reg <= alu_equals;
        lt_flag_reg <= alu_lt;
      end
    end
  end

  assign in_wb        = (state_reg == ST_WB);
  assign branch_taken = (dec_beq & eq_flag_reg) | (dec_blt & lt_flag_reg);

  assign instr_ready = (state_reg == ST_IDLE) & Reset_n;
  assign alu_op      = (state_reg == ST_EXEC) ? dec_alu_op : mcADD;
  assign rf_raddr_a  = raddr_a_reg;
  assign rf_raddr_b  = raddr_b_reg;
  assign rf_we       = in_wb & dec_alu;
  assign rf_waddr    = rf_we ? dec_waddr : 3'd0;
  assign rf_wdata    = rf_we ? result_reg : '0;
  assign pc_load     = in_wb & branch_taken;
  assign pc_inc      = in_wb & ~branch_taken;
  assign pc_offset   = (in_wb & dec_branch) ? dec_offset : '0;
  assign eq_flag     = eq_flag_reg;
  assign lt_flag     = lt_flag_reg;
  assign halted      = (state_reg == ST_HALT);

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      count_reg <= '0;
    else if (in_wb && count_reg != {CNT_W{1'b1}})
      count_reg <= count_reg + 1'b1;
  end

  assign instr_count = count_reg;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small register-file/ALU model on the
// initiator side; expected values are worked out by hand per step.
module tb_alu_issue_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [8:0]  instr = '0;
  logic        instr_ready;
  logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr, alu_op;
  logic        rf_we, eq_flag, lt_flag, pc_inc, pc_load, halted;
  logic [7:0]  rf_wdata, pc_offset, alu_result;
  logic        alu_equals, alu_lt;
  logic [15:0] instr_count;

  logic [7:0]  rf [0:7];
  logic [7:0]  op_a, op_b;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 Clk = ~Clk;

  alu_issue_ctrl dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .rf_waddr    (rf_waddr),
    .rf_we       (rf_we),
    .rf_wdata    (rf_wdata),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_equals  (alu_equals),
    .alu_lt      (alu_lt),
    .eq_flag     (eq_flag),
    .lt_flag     (lt_flag),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .pc_offset   (pc_offset),
    .halted      (halted),
    .instr_count (instr_count)
  );

  // Combinational ALU: ADD and SUB are all this bench exercises
  always_comb begin
    op_a       = rf[rf_raddr_a];
    op_b       = rf[rf_raddr_b];
    alu_result = (alu_op == 3'd1) ? op_a - op_b : op_a + op_b;
    alu_equals = (op_a == op_b);
    alu_lt     = (op_a < op_b);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents w for one accept edge; leaves the DUT in DECODE
  task automatic issue(input logic [8:0] w);
    chk("ready_before_issue", {31'd0, instr_ready}, 32'd1);
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr       = '0;
  endtask

  logic [7:0]  ready_pat, we_pat;
  logic [15:0] exp_cnt;
  logic [3:0]  strobe_seen;

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    rf[1] = 8'h05; rf[2] = 8'h03; rf[3] = 8'h2A; rf[4] = 8'h2A;

    // Reset state
    tick(); tick();
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_pc_inc", {31'd0, pc_inc}, 32'd0);
    chk("rst_eq", {31'd0, eq_flag}, 32'd0);
    chk("rst_count", {16'd0, instr_count}, 32'd0);
    Reset_n = 1'b1;
    tick();
    chk("idle_ready", {31'd0, instr_ready}, 32'd1);

    // ADD r1,r2 : 5+3 -> r1
    issue(9'b0_000_001_10);
    $display("txn ADD r1,r2 accepted");
    chk("add_dec_ready", {31'd0, instr_ready}, 32'd0);
    tick();
    chk("add_exec_op", {29'd0, alu_op}, 32'd0);
    chk("add_exec_ra", {29'd0, rf_raddr_a}, 32'd1);
    chk("add_exec_rb", {29'd0, rf_raddr_b}, 32'd2);
    chk("add_exec_we", {31'd0, rf_we}, 32'd0);
    tick();
    chk("add_wb_we", {31'd0, rf_we}, 32'd1);
    chk("add_wb_waddr", {29'd0, rf_waddr}, 32'd1);
    chk("add_wb_wdata", {24'd0, rf_wdata}, 32'h08);
    chk("add_wb_pc_inc", {31'd0, pc_inc}, 32'd1);
    chk("add_wb_pc_load", {31'd0, pc_load}, 32'd0);
    tick();
    chk("add_post_we", {31'd0, rf_we}, 32'd0);

    // CMP r3,r4 (equal)
    issue(9'b1_10_011_100);
    $display("txn CMP r3,r4 accepted");
    tick();
    chk("cmp_exec_op", {29'd0, alu_op}, 32'd1);
    chk("cmp_exec_ra", {29'd0, rf_raddr_a}, 32'd3);
    chk("cmp_exec_rb", {29'd0, rf_raddr_b}, 32'd4);
    tick();
    chk("cmp_wb_eq", {31'd0, eq_flag}, 32'd1);
    chk("cmp_wb_lt", {31'd0, lt_flag}, 32'd0);
    chk("cmp_wb_we", {31'd0, rf_we}, 32'd0);
    chk("cmp_wb_pc_inc", {31'd0, pc_inc}, 32'd1);
    tick();

    // BEQ -2, taken
    issue(9'b1_00_111110);
    $display("txn BEQ -2 accepted");
    tick();
    chk("beq_exec_op", {29'd0, alu_op}, 32'd0);
    tick();
    chk("beq_wb_load", {31'd0, pc_load}, 32'd1);
    chk("beq_wb_inc", {31'd0, pc_inc}, 32'd0);
    chk("beq_wb_off", {24'd0, pc_offset}, 32'hFE);
    chk("beq_wb_we", {31'd0, rf_we}, 32'd0);
    tick();

    // BLT +5, not taken (lt_flag=0)
    issue(9'b1_01_000101);
    $display("txn BLT +5 accepted");
    tick(); tick();
    chk("blt_nt_inc", {31'd0, pc_inc}, 32'd1);
    chk("blt_nt_load", {31'd0, pc_load}, 32'd0);
    chk("blt_nt_eq", {31'd0, eq_flag}, 32'd1);
    chk("blt_nt_lt", {31'd0, lt_flag}, 32'd0);
    tick();

    // CMP r2,r1 (3<5) then BLT +3, taken
    issue(9'b1_10_010_001);
    $display("txn CMP r2,r1 accepted");
    tick(); tick();
    chk("cmp2_lt", {31'd0, lt_flag}, 32'd1);
    chk("cmp2_eq", {31'd0, eq_flag}, 32'd0);
    tick();
    issue(9'b1_01_000011);
    $display("txn BLT +3 accepted");
    tick(); tick();
    chk("blt_t_load", {31'd0, pc_load}, 32'd1);
    chk("blt_t_inc", {31'd0, pc_inc}, 32'd0);
    chk("blt_t_off", {24'd0, pc_offset}, 32'h03);
    tick();

    // Back-to-back handshake with instr_valid held high
    instr       = 9'b0_000_001_10;
    instr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ready_pat[i] = instr_ready;
      we_pat[i]    = rf_we;
      tick();
    end
    instr_valid = 1'b0;
    $display("txn back-to-back ADD x2 ready=%b we=%b", ready_pat, we_pat);
    chk("b2b_ready_pat", {24'd0, ready_pat}, 32'b0001_0001);
    chk("b2b_we_pat", {24'd0, we_pat}, 32'b1000_1000);
    strobe_seen = '0;
    for (int i = 0; i < 4; i++) begin
      strobe_seen[i] = rf_we | pc_inc | pc_load | ~instr_ready;
      tick();
    end
    chk("idle_no_strobes", {28'd0, strobe_seen}, 32'd0);
`ifdef ALU_ISSUE_PERF_CNT_EN
    exp_cnt = 16'd8;
`else
    exp_cnt = 16'd0;
`endif
    chk("count_after_8", {16'd0, instr_count}, {16'd0, exp_cnt});

    // Reset during EXEC of an ADD, with lt_flag set beforehand
    issue(9'b1_10_010_001);
    tick(); tick(); tick();
    issue(9'b0_000_001_10);
    tick();
    Reset_n = 1'b0;
    #1;
    $display("txn reset during ADD EXEC");
    chk("rst_mid_we", {31'd0, rf_we}, 32'd0);
    chk("rst_mid_lt", {31'd0, lt_flag}, 32'd0);
    chk("rst_mid_ra", {29'd0, rf_raddr_a}, 32'd0);
    chk("rst_mid_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_mid_count", {16'd0, instr_count}, 32'd0);
    tick();
    chk("rst_mid_pc_inc", {31'd0, pc_inc}, 32'd0);
    Reset_n = 1'b1;
    tick();
    for (int n = 0; n < 3; n++) begin
      issue(9'b0_000_001_10);
      tick(); tick(); tick();
    end
`ifdef ALU_ISSUE_PERF_CNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    $display("txn three ADDs retired after reset, count=%0d", instr_count);
    chk("count_three", {16'd0, instr_count}, {16'd0, exp_cnt});

    // HALT absorbs; instr_valid ignored
    issue(9'b1_11_000000);
    $display("txn HALT accepted");
    chk("halt_dec_halted", {31'd0, halted}, 32'd0);
    tick();
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_ready", {31'd0, instr_ready}, 32'd0);
    instr       = 9'b0_000_001_10;
    instr_valid = 1'b1;
    strobe_seen = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      strobe_seen[i] = rf_we | pc_inc | pc_load | instr_ready | ~halted;
    end
    instr_valid = 1'b0;
    chk("halt_absorbing", {28'd0, strobe_seen}, 32'd0);
    chk("halt_count", {16'd0, instr_count}, {16'd0, exp_cnt});
    Reset_n = 1'b0;
    #1;
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    tick();
    Reset_n = 1'b1;
    tick();
    $display("txn reset releases HALT");
    chk("halt_rst_ready", {31'd0, instr_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle control FSM on the initiator side of the combinational ALU.
- Accepts one 9-bit instruction per valid/ready handshake, decodes it, and drives register-file read addresses and the ALU opcode.
- Captures the ALU result and flags, then retires the instruction: register write-back, or a PC increment/load for branches.
- Sits between instruction fetch, register file and ALU.

Parameters:
- DW, 8, datapath width; matches ALU operands and result.
- IW, 9, instruction width.
- CNT_W, 16, width of the retired-instruction counter (optional feature).

Ports:
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  fetch offers an instruction
- instr  in  IW  instruction word
- instr_ready  out  1  controller can accept an instruction
- rf_raddr_a  out  3  register-file read port A (ALU InputA)
- rf_raddr_b  out  3  register-file read port B (ALU InputB)
- rf_waddr  out  3  write-back register address
- rf_we  out  1  write-back strobe, one cycle
- rf_wdata  out  DW  write-back data
- alu_op  out  3  ALU opcode (op_mne encoding)
- alu_result  in  DW  ALU Out
- alu_equals  in  1  ALU equals flag
- alu_lt  in  1  ALU less-than flag
- eq_flag  out  1  registered equals flag
- lt_flag  out  1  registered less-than flag
- pc_inc  out  1  advance PC by 1, one cycle
- pc_load  out  1  PC += pc_offset, one cycle
- pc_offset  out  DW  sign-extended branch offset
- halted  out  1  sticky halt indicator
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Decode:
  - instr[8]=0: ALU class. alu_op=instr[7:5]; rd=instr[4:2] is both source A and destination; rs={1'b0,instr[1:0]}.
  - instr[8]=1: control class, selected by instr[7:6].
  - 00 BEQ, 01 BLT: offset=instr[5:0], signed, sign-extended to DW.
  - 10 CMP: A=instr[5:3], B=instr[2:0], alu_op=SUB, no write-back.
  - 11 HALT.
- States IDLE, DECODE, EXEC, WB, HALT; encoding lives in the package.
- IDLE:
  - instr_ready=1 (forced 0 while Reset_n low).
  - On instr_valid && instr_ready, latch instr into the IR and go to DECODE.
  - instr is ignored when instr_valid is low.
- DECODE:
  - Register rf_raddr_a and rf_raddr_b.
  - HALT instruction: go to HALT directly, with no EXEC or WB.
  - Otherwise go to EXEC.
- EXEC:
  - Drive alu_op combinationally from the IR; the ALU settles within the cycle.
  - ALU class and CMP: latch alu_result into the result register, alu_equals into eq_flag, alu_lt into lt_flag.
  - BEQ/BLT: flags hold; alu_op=ADD (don't-care).
- WB:
  - ALU class: rf_we=1, rf_waddr=rd, rf_wdata=result register.
  - BEQ taken when eq_flag=1; BLT taken when lt_flag=1.
  - Taken branch: pc_load=1 with pc_offset valid. Every other instruction: pc_inc=1.
  - Exactly one of pc_inc/pc_load is high in WB. Next state IDLE.
- HALT: absorbing; instr_ready=0, halted=1, no strobes. Only reset leaves HALT.
- Latency:
  - Accept at edge k; DECODE in cycle k+1, EXEC k+2, WB k+3; instr_ready=1 again at k+4.
  - Throughput is one instruction per 4 cycles.
  - Branches use flags as they stand at their EXEC, i.e. from the most recent ALU/CMP.
- Reset values: state=IDLE, IR=0, result=0, eq_flag=0, lt_flag=0, halted=0, instr_count=0; rf_we, pc_inc, pc_load, alu_op, addresses, pc_offset and rf_wdata all 0.
- Reset mid-instruction: abandon it with no rf_we/pc strobe; flags clear.
- Strobes (rf_we, pc_inc, pc_load) are single-cycle and only in WB.
- Arithmetic wraps modulo 2^DW inside the ALU; this block adds nothing. pc_offset is sign-extended, e.g. 6'b111110 -> 8'hFE.

Optional Feature:
- Macro ALU_ISSUE_PERF_CNT_EN.
- Defined: instr_count increments at each WB exit and saturates at all-ones. HALT does not count. Reset clears it.
- Undefined: the counter logic is absent; the instr_count port remains, tied to 0.

Decomposition:
- Package definitions:
  - Existing op_mne ALU opcode enum.
  - New enum for the controller states.
  - Control-class sub-opcode constants (BEQ/BLT/CMP/HALT).
  - Instruction field bit positions.
- One sub-module, alu_issue_decode: purely combinational IR-to-fields decoder (class, alu_op, addresses, offset, is_branch, is_halt). The FSM stays in the top.

Test Plan:
- Reset, then ADD: rf r1=8'h05, r2=8'h03, instr 9'b0_000_001_10 (ADD r1,r2). Expect alu_op=mcADD at k+2; at k+3 rf_we=1, rf_waddr=1, rf_wdata=8'h08, pc_inc=1.
- CMP r3,r4 (r3=r4=8'h2A), then BEQ offset 6'b111110. Expect eq_flag=1 after the CMP EXEC; BEQ WB pc_load=1, pc_offset=8'hFE, rf_we=0.
- BLT with lt_flag=0. Expect pc_inc=1, pc_load=0; flags unchanged across the branch.
- Handshake: hold instr_valid=1 continuously. Expect acceptance exactly every 4 cycles, instr_ready=0 in DECODE/EXEC/WB. instr_valid=0 leaves the FSM in IDLE with no strobes.
- HALT (9'b1_11_000000). Expect halted=1 from k+2, instr_ready=0 forever, instr_valid ignored. Reset_n low releases it to IDLE.
- Reset asserted during EXEC of an ADD. Expect all outputs 0 immediately, no rf_we. With ALU_ISSUE_PERF_CNT_EN, instr_count counts only fully retired instructions (3 ADDs -> 3).
